wb_stage_sequencer: RTL
=======================

// Module: wb_stage_sequencer
// PURPOSE
//  MEM/WB stage controller for the RISC-V pipeline. Accepts one retiring instruction from MEM.
//  For loads, waits a variable number of cycles for the data-memory response.
//  It then drives the ALU/memory write-back select and the register-file write strobe for one commit cycle.
//  Stalls upstream while a load is outstanding and flags memory-response timeouts.
// PARAMETERS
//  XLEN         64   datapath width (ALU result, load data)
//  REG_AW       5    register address width
//  MEM_TIMEOUT  16   max WAIT_MEM cycles before abandoning a load (>=2)
// PORTS
//  clk          in   1       rising-edge clock
//  rst_n        in   1       reset, synchronous, active-low
//  in_valid     in   1       MEM stage presents an instruction
//  in_ready     out  1       sequencer accepts this cycle (in_valid & in_ready = accept)
//  in_rd        in   REG_AW  destination register
//  in_reg_write in   1       instruction writes rd
//  in_mem_to_reg in  1       1 = load (result from memory), 0 = ALU result
//  in_alu       in   XLEN    ALU result
//  mem_rvalid   in   1       data-memory read response valid (single-cycle pulse)
//  mem_rdata    in   XLEN    load data, valid with mem_rvalid
//  wb_sel       out  1       write-back mux select: 1 = wb_mem, 0 = wb_alu
//  wb_alu       out  XLEN    registered ALU result to mux
//  wb_mem       out  XLEN    registered load data to mux
//  rf_we        out  1       register-file write enable (one-cycle pulse)
//  rf_rd        out  REG_AW  register-file write address
//  stall        out  1       hold MEM and earlier stages
//  timeout_err  out  1       sticky: a load was abandoned on timeout
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state=IDLE; wb_sel, wb_alu, wb_mem, rf_we, rf_rd, timeout_err, counter = 0.
//  States: IDLE, WAIT_MEM, COMMIT. in_ready = (state != WAIT_MEM); stall = (state == WAIT_MEM).
//  Accept (IDLE or COMMIT, in_valid=1): latch in_rd, in_reg_write, in_mem_to_reg, and in_alu into wb_alu.
//   - If in_mem_to_reg=1: go to WAIT_MEM and clear the counter.
//   - If in_mem_to_reg=0: go to COMMIT.
//  IDLE or COMMIT with in_valid=0: go to IDLE.
//  WAIT_MEM:
//   - mem_rvalid=1: latch mem_rdata into wb_mem, go to COMMIT.
//   - mem_rvalid=0: counter += 1.
//     - When the counter reaches MEM_TIMEOUT-1 with no rvalid: set timeout_err, go to IDLE, no write.
//   - rvalid on the timeout cycle wins; it is a normal completion.
//  COMMIT:
//   - rf_we = latched reg_write & (rf_rd != 0). Register x0 is never written.
//   - rf_rd = latched rd.
//   - Exactly one cycle; back-to-back accept allowed in the same cycle.
//  wb_sel = latched mem_to_reg in WAIT_MEM/COMMIT; 0 in IDLE. It is stable throughout COMMIT.
//  Latency:
//   - ALU op accepted at edge N: rf_we is high in cycle N+1.
//   - Load: rf_we is high in the cycle after the rvalid edge.
//   - ALU throughput is 1/cycle.
//  mem_rvalid outside WAIT_MEM is ignored. wb_mem holds its last value.
//  Reset mid-WAIT_MEM: load abandoned, no rf_we; a late rvalid after reset is ignored.
//  timeout_err clears only on reset.
//  Counter width: $clog2(MEM_TIMEOUT); counting saturates, never wraps.
// STRUCTURE
//  Shared package (wb_pkg): XLEN, REG_AW, state enum {IDLE, WAIT_MEM, COMMIT}.
//  One sub-module: wb_timeout_counter (clear, enable, terminal-count output, parameter MEM_TIMEOUT).
//  Remainder of the block: FSM plus latches. The existing write-back mux is instantiated outside the block, driven by wb_sel/wb_alu/wb_mem.
// TESTING
//  1. ALU op: rd=5, alu=0x1234, reg_write=1 -> next cycle rf_we=1, rf_rd=5, wb_sel=0, wb_alu=0x1234.
//  2. Load: rd=7; rvalid after 3 cycles with rdata=0xDEAD_BEEF.
//     -> stall=1 for 3 cycles; next cycle rf_we=1, wb_sel=1, wb_mem=0xDEAD_BEEF.
//  3. Back-to-back ALU ops rd=1,2,3 on consecutive cycles -> rf_we high 3 consecutive cycles, rf_rd=1,2,3, stall=0.
//  4. Load, no rvalid, MEM_TIMEOUT=16 -> after 15 WAIT cycles: IDLE, timeout_err=1, no rf_we; a later rvalid is ignored.
//  5. rd=0 with reg_write=1 -> COMMIT occurs, rf_we=0. Separately, reg_write=0 with rd=9 -> rf_we=0.
//  6. rst_n low during WAIT_MEM -> all outputs 0, in_ready=1 after reset; a later rvalid causes no write.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types for the MEM/WB write-back sequencer.
// Datapath widths, FSM states and the latched control bundle.
package wb_pkg;

    localparam int XLEN   = 64;
    localparam int REG_AW = 5;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_MEM,
        COMMIT
    } state_t;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic              reg_write;
        logic              mem_to_reg;
    } wb_ctl_t;

endpackage

// File: rtl/wb_timeout_counter.sv
// Saturating wait counter for outstanding loads.
// o_tc flags the last permitted wait cycle.
module wb_timeout_counter #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam int CW = $clog2(MEM_TIMEOUT);
    localparam logic [CW-1:0] MAX = CW'(MEM_TIMEOUT - 1);
    localparam logic [CW-1:0] TC  = CW'(MEM_TIMEOUT - 2);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || i_clr) begin
            r_cnt <= '0;
        end else if (i_en && r_cnt != MAX) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Incrementing out of TC lands on MEM_TIMEOUT-1: the abandon point.
    assign o_tc = (r_cnt == TC);

endmodule

// File: rtl/wb_stage_sequencer.sv
// MEM/WB stage controller: waits for load data, then
// drives one register-file commit cycle.
module wb_stage_sequencer
    import wb_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_AW-1:0] in_rd,
    input  logic              in_reg_write,
    input  logic              in_mem_to_reg,
    input  logic [XLEN-1:0]   in_alu,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              wb_sel,
    output logic [XLEN-1:0]   wb_alu,
    output logic [XLEN-1:0]   wb_mem,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_rd,
    output logic              stall,
    output logic              timeout_err
);

    state_t          r_state;
    state_t          w_state_nxt;
    wb_ctl_t         r_ctl;
    logic [XLEN-1:0] r_alu;
    logic [XLEN-1:0] r_mem;
    logic            r_err;
    logic            w_accept;
    logic            w_abandon;
    logic            w_cnt_en;
    logic            w_cnt_clr;
    logic            w_tc;

    wb_timeout_counter #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .i_clr(w_cnt_clr),
        .i_en (w_cnt_en),
        .o_tc (w_tc)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_abandon   = 1'b0;
        w_cnt_en    = 1'b0;
        unique case (r_state)
            IDLE, COMMIT: begin
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = in_mem_to_reg ? WAIT_MEM : COMMIT;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            WAIT_MEM: begin
                if (mem_rvalid) begin
                    w_state_nxt = COMMIT;
                end else begin
                    w_cnt_en = 1'b1;
                    if (w_tc) begin
                        w_abandon   = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_cnt_clr = w_accept & in_mem_to_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ctl <= '0;
            r_alu <= '0;
            r_mem <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_ctl.rd         <= in_rd;
                r_ctl.reg_write  <= in_reg_write;
                r_ctl.mem_to_reg <= in_mem_to_reg;
                r_alu            <= in_alu;
            end
            if (r_state == WAIT_MEM && mem_rvalid) begin
                r_mem <= mem_rdata;
            end
            if (w_abandon) begin
                r_err <= 1'b1;
            end
        end
    end

    // x0 is hardwired zero, so its writes are dropped here.
    assign rf_we = (r_state == COMMIT) & r_ctl.reg_write
                 & (r_ctl.rd != '0);
    assign rf_rd       = r_ctl.rd;
    assign wb_sel      = (r_state != IDLE) & r_ctl.mem_to_reg;
    assign wb_alu      = r_alu;
    assign wb_mem      = r_mem;
    assign in_ready    = (r_state != WAIT_MEM);
    assign stall       = (r_state == WAIT_MEM);
    assign timeout_err = r_err;

endmodule
